// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// WORD is the default datapath width; the FSM state type lives here for the ALU controller.
package seq_divider_pkg;

  localparam int WORD = 42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference when it does not borrow.
module seq_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // One extra bit so a set top bit of the partial remainder never looks like a borrow.
  assign trial = {p_in, bit_in};
  assign diff  = trial - {1'b0, divisor};
  assign q_bit = ~diff[WIDTH];
  assign p_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to add the is_signed port for two's-complement division.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             zero_reg, zero_next;
  logic             dbz_reg, dbz_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, p_step;
  logic             sgn_q, sgn_r, q_bit;

`ifdef DIV_SIGNED_EN
  // Divide magnitudes; remember which results need negating in FIN.
  always_comb begin
    sgn_r   = is_signed & dividend[WIDTH-1];
    sgn_q   = sgn_r ^ (is_signed & divisor[WIDTH-1]);
    dvd_mag = sgn_r ? -dividend : dividend;
    dvs_mag = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
  end
`else
  assign sgn_r   = 1'b0;
  assign sgn_q   = 1'b0;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_reg),
    .bit_in  (dvd_reg[WIDTH-1]),
    .divisor (dvs_reg),
    .p_out   (p_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      p_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      zero_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      p_reg     <= p_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      zero_reg  <= zero_next;
      dbz_reg   <= dbz_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    p_next     = p_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    zero_next  = zero_reg;
    dbz_next   = dbz_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          dvd_next   = dvd_mag;
          dvs_next   = dvs_mag;
          p_next     = '0;
          cnt_next   = '0;
          neg_q_next = sgn_q;
          neg_r_next = sgn_r;
          zero_next  = (divisor == '0);
          state_next = (divisor == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // Quotient bits shift in behind the dividend bits as they are consumed.
        p_next   = p_step;
        dvd_next = {dvd_reg[WIDTH-2:0], q_bit};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT)
          state_next = ST_FIN;
      end
      ST_FIN: begin
        if (zero_reg) begin
          quo_next = '1;
          rem_next = neg_r_reg ? -dvd_reg : dvd_reg;
        end else begin
          quo_next = neg_q_reg ? -dvd_reg : dvd_reg;
          rem_next = neg_r_reg ? -p_reg : p_reg;
        end
        dbz_next   = zero_reg;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake timing and random
// operands against an arithmetic reference model (signed cases under DIV_SIGNED_EN).
module tb_seq_divider;

  localparam int W     = seq_divider_pkg::WORD;
  localparam int LIMIT = W + 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one start and wait (bounded) for done; lat counts clock edges from the accepting edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, output int lat);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    dividend = W'(100); divisor = W'(7); is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin @(negedge clk); lat++; end
    checks++; if (lat != W + 2) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, W + 2); end
    checks++; if (quotient !== W'(14)) begin errors++; $display("FAIL basic_q got %0d want 14", quotient); end
    checks++; if (remainder !== W'(2)) begin errors++; $display("FAIL basic_r got %0d want 2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse done still %b want 0", done); end
    checks++; if (quotient !== W'(14)) begin errors++; $display("FAIL basic_hold got %0d want 14", quotient); end
    $display("basic: 100/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic [W-1:0] eq [5];
    logic [W-1:0] er [5];
    logic         ez [5];
    int lat;
    ta = '{'1, '1, W'(3), W'(1023), W'(5)};
    tb = '{W'(1), '1, W'(10), W'(1024), W'(0)};
    eq = '{'1, W'(1), W'(0), W'(0), '1};
    er = '{W'(0), W'(0), W'(3), W'(1023), W'(5)};
    ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat);
      checks++; if (lat != (ez[i] ? 2 : W + 2)) begin errors++; $display("FAIL bound%0d_latency got %0d want %0d", i, lat, ez[i] ? 2 : W + 2); end
      checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL bound%0d_q got %0d want %0d", i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin errors++; $display("FAIL bound%0d_r got %0d want %0d", i, remainder, er[i]); end
      checks++; if (div_by_zero !== ez[i]) begin errors++; $display("FAIL bound%0d_dbz got %b want %b", i, div_by_zero, ez[i]); end
      $display("bound: %0d/%0d -> q=%0d r=%0d z=%b lat=%0d", ta[i], tb[i], quotient, remainder, div_by_zero, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = W'(100); divisor = W'(7); is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    dividend = W'(999); divisor = W'(0);
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin
      // Extra requests mid-RUN and during the FIN cycle must all be dropped.
      start = (lat >= 5 && lat < 10) || (lat == W + 1);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++; if (lat != W + 2) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, W + 2); end
    checks++; if (quotient !== W'(14)) begin errors++; $display("FAIL ignore_q got %0d want 14", quotient); end
    checks++; if (remainder !== W'(2)) begin errors++; $display("FAIL ignore_r got %0d want 2", remainder); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_fin_start busy got %b want 0", busy); end
    $display("ignore: 100/7 with extra starts -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_abort();
    int  lat;
    logic seen;
    @(negedge clk);
    dividend = W'(100); divisor = W'(7); is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL abort_q got %0d want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL abort_r got %0d want 0", remainder); end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen); end
    run_op(W'(9), W'(3), 1'b0, lat);
    checks++; if (quotient !== W'(3)) begin errors++; $display("FAIL abort_after_q got %0d want 3", quotient); end
    checks++; if (remainder !== W'(0)) begin errors++; $display("FAIL abort_after_r got %0d want 0", remainder); end
    $display("abort: reset mid-run, then 9/3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
  endtask

  // Random operands, issued back to back (start in the cycle after each done).
  task automatic test_random(input logic sgn, input int n);
    logic [W-1:0] a, b, q, r;
    logic z;
    int lat, k;
    for (int i = 0; i < n; i++) begin
      a = W'({$urandom, $urandom});
      k = $urandom_range(0, 7);
      if (k == 0)      b = '0;
      else if (k < 3)  b = W'($urandom_range(1, 1000));
      else             b = W'({$urandom, $urandom}) >> $urandom_range(0, W - 1);
      if (b == '0 && k != 0) b = W'(1);
      run_op(a, b, sgn, lat);
      model(a, b, is_signed, q, r, z);
      checks++; if (lat != (z ? 2 : W + 2)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, z ? 2 : W + 2); end
      checks++; if (quotient !== q) begin errors++; $display("FAIL rand%0d_q %h/%h got %h want %h", i, a, b, quotient, q); end
      checks++; if (remainder !== r) begin errors++; $display("FAIL rand%0d_r %h/%h got %h want %h", i, a, b, remainder, r); end
      checks++; if (div_by_zero !== z) begin errors++; $display("FAIL rand%0d_dbz got %b want %b", i, div_by_zero, z); end
      $display("rand s=%b: %h/%h -> q=%h r=%h z=%b lat=%0d", sgn, a, b, quotient, remainder, div_by_zero, lat);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    longint sa [4];
    longint sb [4];
    longint sq [4];
    longint sr [4];
    logic [W-1:0] a, b;
    int lat;
    sa = '{-7, 7, -(64'sd1 <<< (W - 1)), -5};
    sb = '{2, -2, -1, 0};
    sq = '{-3, -3, -(64'sd1 <<< (W - 1)), -1};
    sr = '{-1, 1, 0, -5};
    for (int i = 0; i < 4; i++) begin
      a = W'(sa[i]);
      b = W'(sb[i]);
      run_op(a, b, 1'b1, lat);
      checks++; if (quotient !== W'(sq[i])) begin errors++; $display("FAIL signed%0d_q got %h want %h", i, quotient, W'(sq[i])); end
      checks++; if (remainder !== W'(sr[i])) begin errors++; $display("FAIL signed%0d_r got %h want %h", i, remainder, W'(sr[i])); end
      checks++; if (div_by_zero !== (sb[i] == 0)) begin errors++; $display("FAIL signed%0d_dbz got %b want %b", i, div_by_zero, sb[i] == 0); end
      $display("signed: %0d/%0d -> q=%h r=%h z=%b lat=%0d", sa[i], sb[i], quotient, remainder, div_by_zero, lat);
    end
    test_random(1'b1, 12);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_reset_abort();
    test_random(1'b0, 25);
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
